// File: rtl/alu_share_arbiter_if.sv
// Bundle between the issue side, the shared ALU and the response consumer
// on one side and alu_share_arbiter on the other.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [5*NUM_REQ-1:0]    req_function;
    logic [32*NUM_REQ-1:0]   req_operand_a;
    logic [32*NUM_REQ-1:0]   req_operand_b;
    logic [4:0]              alu_function;
    logic [31:0]             alu_operand_a;
    logic [31:0]             alu_operand_b;
    logic [31:0]             alu_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_result;
    logic                    rsp_zero;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_err;

    // Environment side: requesters, the ALU itself and the response consumer.
    modport master (
        output req_valid, req_function, req_operand_a, req_operand_b,
        output alu_result, rsp_ready,
        input  req_ready, alu_function, alu_operand_a, alu_operand_b,
        input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_function, req_operand_a, req_operand_b,
        input  alu_result, rsp_ready,
        output req_ready, alu_function, alu_operand_a, alu_operand_b,
        output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters with a
// one-entry tagged response buffer. Optional macro: ALU_ARB_ILLEGAL_CHECK_EN.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     ptr_nxt_s;
    logic                can_issue_s;
    logic                grant_s;
    logic                hit_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic [ID_W:0]       cand_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [4:0]          sel_func_s;
    logic [31:0]         sel_a_s;
    logic [31:0]         sel_b_s;
    logic                illegal_s;
    logic [31:0]         cap_result_s;
    logic [31:0]         rsp_result_r;
    logic                rsp_zero_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic                rsp_err_r;

    function automatic logic func_legal(input logic [4:0] f);
        return (f >= 5'd1) && (f <= 5'd11);
    endfunction

    // Issue is possible into a free buffer or one being drained this cycle; never in reset.
    assign can_issue_s = rst_n & ((state_r == ST_EMPTY) | ((state_r == ST_FULL) & bus.rsp_ready));

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_s   = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s    = {1'b0, ptr_r} + (ID_W+1)'(k);
            cand_s    = (cand_s >= (ID_W+1)'(NUM_REQ)) ? (cand_s - (ID_W+1)'(NUM_REQ)) : cand_s;
            hit_s     = can_issue_s & ~grant_s & bus.req_valid[cand_s[ID_W-1:0]];
            gnt_idx_s = hit_s ? cand_s[ID_W-1:0] : gnt_idx_s;
            grant_s   = grant_s | hit_s;
        end
    end

    // Grant decode and payload mux of the winning requester.
    always_comb begin
        req_ready_s = '0;
        sel_func_s  = 5'd0;
        sel_a_s     = 32'd0;
        sel_b_s     = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i] = grant_s & (gnt_idx_s == ID_W'(i));
            sel_func_s     = req_ready_s[i] ? bus.req_function[5*i +: 5]    : sel_func_s;
            sel_a_s        = req_ready_s[i] ? bus.req_operand_a[32*i +: 32] : sel_a_s;
            sel_b_s        = req_ready_s[i] ? bus.req_operand_b[32*i +: 32] : sel_b_s;
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    assign illegal_s = grant_s & ~func_legal(sel_func_s);
`else
    assign illegal_s = 1'b0;
`endif

    // An illegal code still completes, but with a blanked function and a zero result.
    assign bus.req_ready     = req_ready_s;
    assign bus.alu_function  = illegal_s ? 5'd0 : sel_func_s;
    assign bus.alu_operand_a = sel_a_s;
    assign bus.alu_operand_b = sel_b_s;
    assign cap_result_s      = illegal_s ? 32'd0 : bus.alu_result;

    // State and priority pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state and pointer advance.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        if (grant_s) begin
            ptr_nxt_s = (gnt_idx_s == ID_W'(NUM_REQ-1)) ? '0 : (gnt_idx_s + ID_W'(1));
        end else begin
            ptr_nxt_s = ptr_r;
        end
        case (state_r)
            ST_EMPTY: begin
                state_nxt_s = grant_s ? ST_FULL : ST_EMPTY;
            end
            ST_FULL: begin
                if (grant_s) begin
                    state_nxt_s = ST_FULL;
                end else if (bus.rsp_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Response buffer: loads on every grant, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result_r <= 32'd0;
            rsp_zero_r   <= 1'b0;
            rsp_id_r     <= '0;
            rsp_err_r    <= 1'b0;
        end else if (grant_s) begin
            rsp_result_r <= cap_result_s;
            rsp_zero_r   <= (cap_result_s == 32'd0);
            rsp_id_r     <= gnt_idx_s;
            rsp_err_r    <= illegal_s;
        end else begin
            rsp_result_r <= rsp_result_r;
            rsp_zero_r   <= rsp_zero_r;
            rsp_id_r     <= rsp_id_r;
            rsp_err_r    <= rsp_err_r;
        end
    end

    assign bus.rsp_valid  = (state_r == ST_FULL);
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter (NUM_REQ=3): directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_alu_share_arbiter;
    localparam int N  = 3;
    localparam int IW = $clog2(N);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    alu_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a << b[4:0];
            5'd4:    return a >> b[4:0];
            5'd5:    return $unsigned($signed(a) >>> b[4:0]);
            5'd6:    return a ^ b;
            5'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd8:    return (a < b) ? 32'd1 : 32'd0;
            5'd9:    return a & b;
            5'd10:   return a | b;
            5'd11:   return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb bus.alu_result = alu_model(bus.alu_function, bus.alu_operand_a, bus.alu_operand_b);

    int checks = 0;
    int errors = 0;

    logic [N-1:0] val_q;
    logic [4:0]   fn_q [N];
    logic [31:0]  a_q  [N];
    logic [31:0]  b_q  [N];
    logic         rr_q;

    int          m_ptr;
    bit          m_full;
    logic [31:0] m_res;
    bit          m_zero;
    int          m_id;
    bit          m_err;
    int          last_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_function[5*i +: 5]    = fn_q[i];
            bus.req_operand_a[32*i +: 32] = a_q[i];
            bus.req_operand_b[32*i +: 32] = b_q[i];
        end
        bus.req_valid = val_q;
        bus.rsp_ready = rr_q;
        #1;
    endtask

    task automatic set_all(input bit rst, input bit rr, input logic [N-1:0] v,
                           input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        rst_n = rst;
        rr_q  = rr;
        val_q = v;
        for (int i = 0; i < N; i++) begin
            fn_q[i] = f;
            a_q[i]  = a;
            b_q[i]  = b;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_full = 0; m_res = 32'd0; m_zero = 0; m_id = 0; m_err = 0;
    endtask

    // Check against the model with inputs settled, then advance one clock.
    task automatic run_cycle();
        int g;
        bit ill;
        logic [N-1:0] er;
        logic [4:0]   ef;
        logic [31:0]  ea, eb, r;
        g  = (rst_n && (!m_full || rr_q)) ? pick(val_q, m_ptr) : -1;
        er = '0; ef = 5'd0; ea = 32'd0; eb = 32'd0; ill = 1'b0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ill   = CHK_EN && !(fn_q[g] inside {[5'd1:5'd11]});
            ef    = ill ? 5'd0 : fn_q[g];
            ea    = a_q[g];
            eb    = b_q[g];
        end
        chk("m_req_ready", 32'(bus.req_ready), 32'(er));
        chk("m_alu_function", 32'(bus.alu_function), 32'(ef));
        chk("m_alu_a", bus.alu_operand_a, ea);
        chk("m_alu_b", bus.alu_operand_b, eb);
        chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
        chk("m_rsp_result", bus.rsp_result, m_res);
        chk("m_rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
        chk("m_rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("m_rsp_err", 32'(bus.rsp_err), 32'(m_err));
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            r      = ill ? 32'd0 : alu_model(fn_q[g], a_q[g], b_q[g]);
            m_res  = r;
            m_zero = (r == 32'd0);
            m_id   = g;
            m_err  = ill;
            m_full = 1;
            m_ptr  = (g + 1) % N;
        end else if (m_full && rr_q) begin
            m_full = 0;
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit           rst;
        bit           rr;
        logic [N-1:0] val;
        logic [4:0]   fn;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [N-1:0] e_ready;
        bit           e_valid;
        logic [31:0]  e_res;
        bit           e_zero;
        int           e_id;
        bit           e_err;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(bit rst, bit rr, logic [N-1:0] v, logic [4:0] f, logic [31:0] a, logic [31:0] b,
                                logic [N-1:0] er, bit ev, logic [31:0] eres, bit ez, int eid, bit eerr);
        vec_t t;
        t.rst = rst; t.rr = rr; t.val = v; t.fn = f; t.a = a; t.b = b;
        t.e_ready = er; t.e_valid = ev; t.e_res = eres; t.e_zero = ez; t.e_id = eid; t.e_err = eerr;
        return t;
    endfunction

    initial begin
        logic [31:0] ill_res;
        ill_res = CHK_EN ? 32'd0 : 32'hDEAD_BEEF;
        // rst rr valid fn a b | ready(now) valid result zero id err (after the edge)
        tbl[0]  = mk(0, 0, 3'b111, 5'd0, 32'd0,        32'd0,  3'b000, 0, 32'd0,         0, 0, 0);
        tbl[1]  = mk(1, 1, 3'b001, 5'd1, 32'd5,        32'd7,  3'b001, 1, 32'd12,        0, 0, 0);
        tbl[2]  = mk(1, 0, 3'b010, 5'd2, 32'd9,        32'd9,  3'b000, 1, 32'd12,        0, 0, 0);
        tbl[3]  = mk(1, 1, 3'b010, 5'd2, 32'd9,        32'd9,  3'b010, 1, 32'd0,         1, 1, 0);
        tbl[4]  = mk(1, 1, 3'b011, 5'd3, 32'd1,        32'd31, 3'b001, 1, 32'h8000_0000, 0, 0, 0);
        tbl[5]  = mk(1, 1, 3'b111, 5'd8, 32'hFFFF_FFFF, 32'd1, 3'b010, 1, 32'd0,         1, 1, 0);
        tbl[6]  = mk(1, 1, 3'b000, 5'd1, 32'd0,        32'd0,  3'b000, 0, 32'd0,         1, 1, 0);
        tbl[7]  = mk(1, 0, 3'b101, 5'd1, 32'hFFFF_FFFF, 32'd1, 3'b100, 1, 32'd0,         1, 2, 0);
        tbl[8]  = mk(0, 0, 3'b111, 5'd1, 32'd3,        32'd3,  3'b000, 0, 32'd0,         0, 0, 0);
        tbl[9]  = mk(1, 0, 3'b110, 5'd2, 32'd10,       32'd3,  3'b010, 1, 32'd7,         0, 1, 0);
        tbl[10] = mk(1, 1, 3'b001, 5'd15, 32'd1,       32'd2,  3'b001, 1, ill_res,       CHK_EN, 0, CHK_EN);
        tbl[11] = mk(1, 1, 3'b000, 5'd1, 32'd0,        32'd0,  3'b000, 0, ill_res,       CHK_EN, 0, CHK_EN);

        last_g = -1;
        set_all(0, 0, '0, 5'd0, 32'd0, 32'd0);
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        for (int t = 0; t < 12; t++) begin
            set_all(tbl[t].rst, tbl[t].rr, tbl[t].val, tbl[t].fn, tbl[t].a, tbl[t].b);
            apply();
            chk($sformatf("tbl%0d_ready", t), 32'(bus.req_ready), 32'(tbl[t].e_ready));
            run_cycle();
            chk($sformatf("tbl%0d_valid", t), 32'(bus.rsp_valid), 32'(tbl[t].e_valid));
            chk($sformatf("tbl%0d_result", t), bus.rsp_result, tbl[t].e_res);
            chk($sformatf("tbl%0d_zero", t), 32'(bus.rsp_zero), 32'(tbl[t].e_zero));
            chk($sformatf("tbl%0d_id", t), 32'(bus.rsp_id), 32'(tbl[t].e_id));
            chk($sformatf("tbl%0d_err", t), 32'(bus.rsp_err), 32'(tbl[t].e_err));
        end

        // Round-robin with every requester continuously valid.
        set_all(0, 1, 3'b111, 5'd1, 32'd4, 32'd5);
        apply();
        run_cycle();
        set_all(1, 1, 3'b111, 5'd1, 32'd4, 32'd5);
        for (int k = 0; k < 6; k++) begin
            apply();
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (k % N));
            run_cycle();
            chk("rr_id", 32'(bus.rsp_id), 32'(k % N));
        end

        // Backpressure: response held while req0 waits, then req0 wins as the buffer drains.
        set_all(1, 1, 3'b010, 5'd2, 32'd9, 32'd9);
        apply();
        run_cycle();
        set_all(1, 0, 3'b001, 5'd1, 32'd5, 32'd7);
        for (int k = 0; k < 4; k++) begin
            apply();
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_result", bus.rsp_result, 32'd0);
            chk("bp_zero", 32'(bus.rsp_zero), 32'd1);
            chk("bp_id", 32'(bus.rsp_id), 32'd1);
            run_cycle();
        end
        rr_q = 1'b1;
        apply();
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        run_cycle();
        chk("bp_release_result", bus.rsp_result, 32'd12);
        chk("bp_release_id", 32'(bus.rsp_id), 32'd0);

        // Random traffic; a requester keeps valid and payload until it is granted.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            rr_q  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(val_q[i] && last_g != i)) begin
                    val_q[i] = ($urandom_range(0, 2) != 0);
                    fn_q[i]  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 11));
                    a_q[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    b_q[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                end
            end
            apply();
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single-cycle combinational `alu` between up to four requesters (e.g. integer pipe, address-generation unit, branch unit). It accepts one operation per cycle through valid/ready handshakes, drives the ALU's function and operand inputs, and captures the result in a one-entry response buffer with backpressure. The buffer is tagged with the requester index. The block sits between the issue logic and the shared `alu` instance.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester operation valid.
- `req_ready`  out  NUM_REQ  per-requester accept; combinational; one-hot or zero.
- `req_function`  in  5*NUM_REQ  packed ALU function codes; requester i occupies bits [5i+4:5i].
- `req_operand_a`  in  32*NUM_REQ  packed operand A; requester i occupies bits [32i+31:32i].
- `req_operand_b`  in  32*NUM_REQ  packed operand B; same packing as A.
- `alu_function`  out  5  to `alu`; 0 when no grant.
- `alu_operand_a`  out  32  to `alu`; 0 when no grant.
- `alu_operand_b`  out  32  to `alu`; 0 when no grant.
- `alu_result`  in  32  from `alu`; combinational.
- `rsp_valid`  out  1  response buffer occupied.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  registered result.
- `rsp_zero`  out  1  registered flag; 1 when `rsp_result == 0`.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_err`  out  1  illegal function code flag (see Configuration).

## Operation
- **States:**
  - EMPTY: response buffer free.
  - FULL: buffer holds an unconsumed response.
- **Issue condition:** `can_issue = (state==EMPTY) | (rsp_valid & rsp_ready)`.
- **Arbitration:**
  - The arbiter grants only when `can_issue` is true.
  - It grants the first asserted `req_valid` at or after priority pointer `ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]=1` only for the granted index g. All other bits are 0.
  - A requester must hold valid and payload stable until it sees ready.
- **Pointer update:** on a grant, `ptr <= (g+1) mod NUM_REQ`. Without a grant, `ptr` holds.
- **ALU drive:** on a grant, the requester g payload is muxed onto `alu_*`, and `alu_result` is captured into `rsp_result` on the same edge.
- **Buffer capture:** on a grant, the buffer loads `rsp_zero`, `rsp_id=g` and `rsp_err`.
- **Transitions:**
  - EMPTY→FULL on a grant.
  - FULL→EMPTY when the response is consumed and there is no grant.
  - FULL→FULL when the response is consumed and a new grant occurs in the same cycle (back-to-back).
  - FULL→FULL when `rsp_ready=0`; the buffer holds unchanged.
- **Fairness:** with all requesters continuously valid and `rsp_ready=1`, grants rotate 0,1,…,NUM_REQ-1 and no requester waits more than NUM_REQ-1 grants.
- **Pass-through codes:** function codes pass through unmodified; legal codes are 1..11.

## Timing
- **Latency:** 1 cycle. Handshake in cycle N gives `rsp_valid` in cycle N+1.
- **Throughput:** one operation per cycle while `rsp_ready=1`.
- **Reset values:**
  - `rsp_valid=0`, `rsp_result=0`, `rsp_zero=0`, `rsp_id=0`, `rsp_err=0`.
  - `ptr=0`, state EMPTY.
  - `req_ready=0`, and `alu_*` outputs are 0 while `rst_n=0`.
- **Reset mid-operation:** reset while FULL discards the pending response. No grant is issued in the reset cycle.
- **No combinational paths:** nothing goes from `rsp_ready` to `rsp_*`. `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state.

## Configuration
- **Macro:** `ALU_ARB_ILLEGAL_CHECK_EN`.
- **Defined:**
  - A granted function code outside 1..11 (0, 12..31) still issues and completes normally.
  - The captured result is forced to 0, `rsp_zero=1` and `rsp_err=1`.
  - `alu_function` is driven to 0 for that cycle.
- **Undefined:**
  - `rsp_err` is tied to 0.
  - Any code is forwarded unchanged and `alu_result` is captured as-is.

## Test plan
- **Reset and single issue:** reset, then req0 ADD (1) with A=5, B=7. Required: `req_ready=2'b01` in the same cycle; next cycle `rsp_valid=1`, `rsp_result=12`, `rsp_zero=0`, `rsp_id=0`.
- **Round-robin:** NUM_REQ=3, all three valid continuously, `rsp_ready=1`. Required: grants 0,1,2,0,1,2 on consecutive cycles and `rsp_id` follows one cycle later.
- **Backpressure:** req1 SUB (2) with A=B=9, `rsp_ready=0` for 4 cycles while req0 stays valid. Required: `rsp_result=0`, `rsp_zero=1`, `rsp_id=1` held stable and `req_ready=0` for those cycles; when `rsp_ready` rises, req0 is granted in the same cycle.
- **Illegal code:** req0 function 0 or 15.
  - With the macro: `rsp_err=1`, `rsp_result=0`, `rsp_zero=1`.
  - Without the macro: `rsp_err=0`.
- **Reset while FULL:** reset asserted while FULL with `rsp_ready=0`. Required: next cycle `rsp_valid=0`, `ptr=0`, and the first grant after reset goes to the lowest valid index.
- **Shift and SLTU:** SLL (3) A=1, B=31 gives 0x80000000. SLTU (8) A=0xFFFFFFFF, B=1 gives 0.
